tt_prog_lut_cell: RTL and testbench

- Tiny Tapeout user tile. Generalises the fixed (a|b)&c gate into a K-input programmable look-up table (LUT).
- Truth table is loaded serially and committed atomically. Output is available both combinational and registered.
- Registered output feeds a rising-edge detector and a saturating event counter.
- Reset truth table reproduces (a|b)&c, so an unconfigured tile behaves as the earlier gate on io_out[1], one cycle later.

---
 rtl/tt_prog_lut_pkg.sv | 27 ++
 rtl/tt_edge_counter.sv | 53 +++++
 rtl/tt_prog_lut_cell.sv | 116 +++++++++++
 tb/tb_tt_prog_lut_cell.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tt_prog_lut_pkg.sv
// rtl/tt_prog_lut_pkg.sv - shared types, widths and helpers for the programmable LUT tile
// Purpose: FSM state type, truth-table length helper, bit-counter width, index clamp.
// Ports: none (package).
package tt_prog_lut_pkg;

    // Largest supported LUT fan-in; the index helpers are sized for it.
    localparam int MAX_K = 3;

    // Bit counter must reach 2^K+1 (one past a full load) so an over-long
    // load stays distinguishable from an exact one.
    localparam int BITCNT_W = MAX_K + 2;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    function automatic int tt_len(input int k);
        return 1 << k;
    endfunction

    // Masks the select inputs down to k bits so the table index is always in range.
    function automatic logic [MAX_K-1:0] clamp_idx(input logic [MAX_K-1:0] x, input int k);
        return x & MAX_K'((1 << k) - 1);
    endfunction

endpackage

// File: rtl/tt_edge_counter.sv
// rtl/tt_edge_counter.sv - rising-edge pulse and saturating event counter for lut_q
// Purpose: registered pulse on a 0->1 transition of lut_q plus a saturating count.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   lut_d_i      next-state value of lut_q
//   lut_q_i      current registered lut_q
//   cnt_clr_i    synchronous counter clear, wins over an increment
//   edge_pulse_o one-cycle pulse, high in the cycle lut_q is newly 1
//   edge_cnt_o   saturating rising-edge count
module tt_edge_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lut_d_i,
    input  logic             lut_q_i,
    input  logic             cnt_clr_i,
    output logic             edge_pulse_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Looking at the next value of lut_q lets the pulse line up with the
    // cycle in which lut_q itself first reads 1.
    always_comb begin
        pulse_d = lut_d_i & ~lut_q_i;
        cnt_d   = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (pulse_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign edge_pulse_o = pulse_q;
    assign edge_cnt_o   = cnt_q;

endmodule

// File: rtl/tt_prog_lut_cell.sv
// rtl/tt_prog_lut_cell.sv - Tiny Tapeout tile: serially programmable K-input LUT
// Purpose: serial truth-table load with atomic commit, combinational and registered
//          LUT output, edge pulse and saturating edge counter.
// Ports:
//   io_in[0] clk, io_in[1] reset (async, active-high), io_in[2] cfg_en,
//   io_in[3] cfg_din, io_in[3+K:4] lut_x {c,b,a}, io_in[7] cnt_clr
//   io_out[0] lut_comb, io_out[1] lut_q, io_out[2] cfg_err,
//   io_out[3] edge_pulse, io_out[3+CNT_W:4] edge_cnt, remaining bits 0
module tt_prog_lut_cell
    import tt_prog_lut_pkg::*;
#(
    parameter int          K        = 3,
    parameter int          CNT_W    = 4,
    parameter logic [7:0]  RESET_TT = 8'hE0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int TT_LEN = tt_len(K);
    localparam logic [BITCNT_W-1:0] LEN_C = BITCNT_W'(TT_LEN);
    localparam logic [BITCNT_W-1:0] SAT_C = BITCNT_W'(TT_LEN + 1);

    logic             clk, rst, cfg_en, cfg_din, cnt_clr;
    logic [MAX_K-1:0] lut_x;
    logic [MAX_K-1:0] idx;

    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign cfg_en  = io_in[2];
    assign cfg_din = io_in[3];
    assign cnt_clr = io_in[7];
    assign lut_x   = MAX_K'(io_in[3+K:4]);
    assign idx     = clamp_idx(lut_x, K);

    state_e              state_q;
    logic [TT_LEN-1:0]   tt_active_q;
    logic [TT_LEN-1:0]   tt_shadow_q;
    logic [TT_LEN-1:0]   tt_shifted;
    logic [BITCNT_W-1:0] bitcnt_q;
    logic                cfg_err_q;
    logic                lut_q, lut_d;
    logic                lut_comb;
    logic                edge_pulse;
    logic [CNT_W-1:0]    edge_cnt;

    assign lut_comb   = tt_active_q[idx[K-1:0]];
    // New bits enter at the top so the first bit loaded lands at index 0.
    assign tt_shifted = {cfg_din, tt_shadow_q[TT_LEN-1:1]};

    // The registered output only samples in steady RUN; it holds on the
    // RUN->LOAD cycle, throughout LOAD and on the commit cycle.
    assign lut_d = ((state_q == RUN) && !cfg_en) ? lut_comb : lut_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            tt_active_q <= RESET_TT[TT_LEN-1:0];
            tt_shadow_q <= '0;
            bitcnt_q    <= '0;
            cfg_err_q   <= 1'b0;
            lut_q       <= 1'b0;
        end else begin
            lut_q <= lut_d;
            case (state_q)
                RUN: begin
                    if (cfg_en) begin
                        state_q     <= LOAD;
                        tt_shadow_q <= tt_shifted;
                        bitcnt_q    <= BITCNT_W'(1);
                    end
                end
                LOAD: begin
                    if (cfg_en) begin
                        tt_shadow_q <= tt_shifted;
                        if (bitcnt_q != SAT_C) begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end else begin
                        // Only an exact-length load replaces the active table.
                        if (bitcnt_q == LEN_C) begin
                            tt_active_q <= tt_shadow_q;
                            cfg_err_q   <= 1'b0;
                        end else begin
                            cfg_err_q   <= 1'b1;
                        end
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    tt_edge_counter #(
        .CNT_W(CNT_W)
    ) u_edge_counter (
        .clk_i       (clk),
        .rst_i       (rst),
        .lut_d_i     (lut_d),
        .lut_q_i     (lut_q),
        .cnt_clr_i   (cnt_clr),
        .edge_pulse_o(edge_pulse),
        .edge_cnt_o  (edge_cnt)
    );

    always_comb begin
        io_out              = '0;
        io_out[0]           = lut_comb;
        io_out[1]           = lut_q;
        io_out[2]           = cfg_err_q;
        io_out[3]           = edge_pulse;
        io_out[3+CNT_W:4]   = edge_cnt;
    end

endmodule

// File: tb/tb_tt_prog_lut_cell.sv
// tb/tb_tt_prog_lut_cell.sv - scoreboard testbench for tt_prog_lut_cell
module tb_tt_prog_lut_cell;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_en = 1'b0, cfg_din = 1'b0, cnt_clr = 1'b0;
    logic [2:0] lut_x = 3'b000;
    logic [7:0] io_in, io_out;

    assign io_in = {cnt_clr, lut_x, cfg_din, cfg_en, rst, clk};

    tt_prog_lut_cell #(.K(3), .CNT_W(4), .RESET_TT(8'hE0)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       q;
        logic       err;
        logic       pulse;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses_seen = 0;

    // Reference model state
    logic [7:0] m_active = 8'hE0;
    logic [7:0] m_shadow = 8'h00;
    int         m_bitcnt = 0;
    logic       m_load = 1'b0;
    logic       m_err = 1'b0;
    logic       m_q = 1'b0;
    logic       m_pulse = 1'b0;
    logic [3:0] m_cnt = 4'd0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 8'hE0; m_shadow = 8'h00; m_bitcnt = 0; m_load = 1'b0;
        m_err = 1'b0; m_q = 1'b0; m_pulse = 1'b0; m_cnt = 4'd0;
    endtask

    // One clock: drive inputs, predict, push; after the edge pop and compare.
    task automatic step(input logic en, input logic din, input logic [2:0] x, input logic clr);
        exp_t e;
        logic nq;
        cfg_en = en; cfg_din = din; lut_x = x; cnt_clr = clr;
        #1;
        check("lut_comb", io_out[0], m_active[x]);
        nq = (!m_load && !en) ? m_active[x] : m_q;
        m_pulse = nq & ~m_q;
        if (clr) m_cnt = 4'd0;
        else if (m_pulse && m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
        m_q = nq;
        if (!m_load) begin
            if (en) begin
                m_load = 1'b1; m_shadow = {din, m_shadow[7:1]}; m_bitcnt = 1;
            end
        end else if (en) begin
            m_shadow = {din, m_shadow[7:1]};
            if (m_bitcnt < 9) m_bitcnt++;
        end else begin
            if (m_bitcnt == 8) begin
                m_active = m_shadow; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_load = 1'b0;
        end
        e.q = m_q; e.err = m_err; e.pulse = m_pulse; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("lut_q", io_out[1], e.q);
        check("cfg_err", io_out[2], e.err);
        check("edge_pulse", io_out[3], e.pulse);
        check("edge_cnt", io_out[7:4], e.cnt);
        if (io_out[3]) pulses_seen++;
    endtask

    task automatic load(input logic [15:0] val, input int nbits, input logic [2:0] x);
        for (int i = 0; i < nbits; i++) step(1'b1, val[i], x, 1'b0);
        step(1'b0, 1'b0, x, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] pat [4];
        int         cnt_before;
        pat[0] = 3'b101; pat[1] = 3'b011; pat[2] = 3'b100; pat[3] = 3'b001;

        #2;
        check("reset_io_out", io_out, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Unconfigured tile behaves as (a|b)&c
        for (int i = 0; i < 4; i++) begin
            lut_x = pat[i];
            #1;
            check("gate_comb", io_out[0], (pat[i][0] | pat[i][1]) & pat[i][2]);
            step(1'b0, 1'b0, pat[i], 1'b0);
            check("gate_q", io_out[1], (pat[i][0] | pat[i][1]) & pat[i][2]);
        end

        // Correct XOR3 load
        load(16'h0096, 8, 3'b000);
        check("xor_err", io_out[2], 0);
        step(1'b0, 1'b0, 3'b111, 1'b0);
        check("xor_111", io_out[0], 1);
        step(1'b0, 1'b0, 3'b011, 1'b0);
        check("xor_011", io_out[0], 0);

        // Short then long load keep XOR3 and flag error
        load(16'h0000, 5, 3'b011);
        check("short_err", io_out[2], 1);
        step(1'b0, 1'b0, 3'b111, 1'b0);
        check("short_keep", io_out[0], 1);
        load(16'h0000, 9, 3'b011);
        check("long_err", io_out[2], 1);
        step(1'b0, 1'b0, 3'b011, 1'b0);
        check("long_keep", io_out[0], 0);
        load(16'h0096, 8, 3'b011);
        check("reload_err", io_out[2], 0);

        // 20 rising edges, counter saturates at 15
        step(1'b0, 1'b0, 3'b011, 1'b1);
        pulses_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 3'b111, 1'b0);
            step(1'b0, 1'b0, 3'b011, 1'b0);
        end
        check("pulse_total", pulses_seen, 20);
        check("cnt_sat", io_out[7:4], 15);
        step(1'b0, 1'b0, 3'b011, 1'b1);
        check("cnt_clr", io_out[7:4], 0);
        step(1'b0, 1'b0, 3'b111, 1'b0);
        step(1'b0, 1'b0, 3'b011, 1'b0);
        step(1'b0, 1'b0, 3'b111, 1'b1);
        check("clr_vs_edge_cnt", io_out[7:4], 0);
        check("clr_vs_edge_pulse", io_out[3], 1);

        // Load XNOR3 while toggling lut_x: registered path holds
        step(1'b0, 1'b0, 3'b011, 1'b0);
        cnt_before = int'(io_out[7:4]);
        for (int i = 0; i < 8; i++) step(1'b1, 8'h69 >> i, (i % 2 == 0) ? 3'b111 : 3'b011, 1'b0);
        check("load_hold_q", io_out[1], 0);
        check("load_hold_cnt", io_out[7:4], cnt_before);
        step(1'b0, 1'b0, 3'b111, 1'b0);
        check("commit_old_tbl_q", io_out[1], 0);
        step(1'b0, 1'b0, 3'b111, 1'b0);
        check("xnor_111", io_out[1], 0);
        step(1'b0, 1'b0, 3'b011, 1'b0);
        check("xnor_011", io_out[1], 1);

        // Short load error, then reset mid-load restores everything
        load(16'h0000, 3, 3'b011);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b011, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_q", io_out[1], 0);
        check("rst_err", io_out[2], 0);
        check("rst_pulse", io_out[3], 0);
        check("rst_cnt", io_out[7:4], 0);
        model_reset();
        cfg_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lut_x = 3'b110;
        #1;
        check("rst_tbl_110", io_out[0], 1);
        step(1'b0, 1'b0, 3'b110, 1'b0);
        step(1'b0, 1'b0, 3'b010, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
